// File: rtl/demux216_q.sv
//------------------------------------------------------------------------------
// Module   : demux216_q
// Purpose  : 1-to-2 stream demultiplexer. Each output channel has a 2-entry
//            FIFO and an optional saturating delivered-word counter.
// Options  : DEMUX216_CNT_EN - include the per-channel transfer counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux216_q #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  input  logic             cnt_clr,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);

  localparam logic [1:0] c_occ_full = 2'd2;
  localparam logic [7:0] c_cnt_max  = 8'd255;

  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [1:0]       w_valid;
  logic [1:0]       w_notfull;
  logic [1:0]       w_oready;
  logic [WIDTH-1:0] w_head [2];

  assign w_oready = {out1_ready, out0_ready};

  // Readiness looks only at the addressed FIFO's current occupancy, so a full
  // FIFO stays blocked even when it is being drained in the same cycle.
  assign in_ready = in_sel ? w_notfull[1] : w_notfull[0];

  for (genvar k = 0; k < 2; k++) begin : g_ch
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_occ;

    assign w_push[k]    = in_valid && in_ready && (in_sel == 1'(k));
    assign w_pop[k]     = w_valid[k] && w_oready[k];
    assign w_valid[k]   = (r_occ != 2'd0);
    assign w_notfull[k] = (r_occ != c_occ_full);
    assign w_head[k]    = r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mem[0] <= '0;
        r_mem[1] <= '0;
        r_wptr   <= 1'b0;
        r_rptr   <= 1'b0;
        r_occ    <= 2'd0;
      end else begin
        if (w_push[k]) begin
          r_mem[r_wptr] <= in_data;
          r_wptr        <= ~r_wptr;
        end
        if (w_pop[k]) begin
          r_rptr <= ~r_rptr;
        end
        case ({w_push[k], w_pop[k]})
          2'b10:   r_occ <= r_occ + 2'd1;
          2'b01:   r_occ <= r_occ - 2'd1;
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out0_data  = w_head[0];
  assign out1_data  = w_head[1];

`ifdef DEMUX216_CNT_EN
  logic [7:0] r_cnt [2];

  for (genvar k = 0; k < 2; k++) begin : g_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt[k] <= 8'd0;
      end else if (cnt_clr) begin
        r_cnt[k] <= 8'd0;
      end else if (w_pop[k] && (r_cnt[k] != c_cnt_max)) begin
        r_cnt[k] <= r_cnt[k] + 8'd1;
      end
    end
  end

  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = cnt_clr;
  assign cnt0             = 8'd0;
  assign cnt1             = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux216_q.sv
//------------------------------------------------------------------------------
// Module   : tb_demux216_q
// Purpose  : Self-checking bench for demux216_q against a queue-based model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_demux216_q;

`ifdef DEMUX216_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_sel;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [15:0] out1_data;
  logic        cnt_clr;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per channel plus delivered-word tallies.
  logic [15:0] m0[$];
  logic [15:0] m1[$];
  int          mc0 = 0;
  int          mc1 = 0;

  demux216_q #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_cnt(input int c);
    return CNT_EN ? 8'(c) : 8'd0;
  endfunction

  // Advance one rising edge, updating the model from the pre-edge inputs.
  task automatic cycle();
    bit acc, p0, p1, clr;
    logic [15:0] d;
    bit s;
    acc = in_valid && (in_sel ? (m1.size() < 2) : (m0.size() < 2));
    p0  = out0_ready && (m0.size() > 0);
    p1  = out1_ready && (m1.size() > 0);
    clr = cnt_clr;
    d   = in_data;
    s   = in_sel;
    @(posedge clk);
    if (p0) void'(m0.pop_front());
    if (p1) void'(m1.pop_front());
    if (acc) begin
      if (s) m1.push_back(d);
      else   m0.push_back(d);
    end
    if (clr) begin
      mc0 = 0;
      mc1 = 0;
    end else begin
      if (p0 && mc0 < 255) mc0++;
      if (p1 && mc1 < 255) mc1++;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_data = '0; in_sel = 0;
    out0_ready = 0; out1_ready = 0; cnt_clr = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b%b exp=00", out1_valid, out0_valid); end
    checks++; if (out0_data !== 16'h0 || out1_data !== 16'h0) begin
      errors++; $display("FAIL reset_data got=%h/%h exp=0000/0000", out0_data, out1_data); end
    checks++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt0, cnt1); end
    rst = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    in_valid = 1; in_sel = 0; in_data = 16'h1234;
    #1;
    checks++; if (in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_ready got=%b exp=1", in_ready); end
    cycle();
    in_valid = 0;
    #1;
    checks++; if (out0_valid !== 1'b1 || out0_data !== 16'h1234) begin
      errors++; $display("FAIL basic_out0 got=%b/%h exp=1/1234", out0_valid, out0_data); end
    checks++; if (out1_valid !== 1'b0) begin
      errors++; $display("FAIL basic_out1_valid got=%b exp=0", out1_valid); end
    out0_ready = 1;
    cycle();
    out0_ready = 0;
    #1;
    checks++; if (out0_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain got=%b exp=0", out0_valid); end
  endtask

  task automatic test_full_block();
    logic [15:0] words [3];
    words[0] = 16'hA001; words[1] = 16'hA002; words[2] = 16'hA003;
    out1_ready = 0; in_sel = 1; in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      in_data = words[i];
      cycle();
    end
    in_data = words[2];
    #1;
    checks++; if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_block_ready got=%b exp=0", in_ready); end
    in_sel = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin
      errors++; $display("FAIL full_other_ready got=%b exp=1", in_ready); end
    in_sel = 1;
    cycle();  // third word must be refused
    in_valid = 0;
    #1;
    checks++; if (out1_data !== 16'hA001 || out1_valid !== 1'b1) begin
      errors++; $display("FAIL full_hold got=%b/%h exp=1/a001", out1_valid, out1_data); end
    out1_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (i < 2) begin
        checks++; if (out1_valid !== 1'b1 || out1_data !== words[i]) begin
          errors++; $display("FAIL full_order[%0d] got=%b/%h exp=1/%h", i, out1_valid, out1_data, words[i]); end
      end else begin
        checks++; if (out1_valid !== 1'b0) begin
          errors++; $display("FAIL full_empty got=%b exp=0", out1_valid); end
      end
      cycle();
    end
    out1_ready = 0;
  endtask

  task automatic test_push_pop();
    in_valid = 1; in_sel = 0; in_data = 16'h0001;
    cycle();
    in_data = 16'h0002; out0_ready = 1;
    #1;
    checks++; if (out0_data !== 16'h0001 || in_ready !== 1'b1) begin
      errors++; $display("FAIL pushpop_pre got=%h/%b exp=0001/1", out0_data, in_ready); end
    cycle();
    in_valid = 0; out0_ready = 0;
    #1;
    checks++; if (out0_valid !== 1'b1 || out0_data !== 16'h0002) begin
      errors++; $display("FAIL pushpop_post got=%b/%h exp=1/0002", out0_valid, out0_data); end
    out0_ready = 1;
    cycle();
    out0_ready = 0;
    #1;
    checks++; if (out0_valid !== 1'b0) begin
      errors++; $display("FAIL pushpop_single got=%b exp=0", out0_valid); end
  endtask

  task automatic test_counters();
    int hs = 0;
    in_valid = 1; in_sel = 1; out1_ready = 1;
    for (int i = 0; i < 400 && hs < 300; i++) begin
      in_data = 16'(i);
      if (out1_valid) hs++;
      cycle();
    end
    #1;
    checks++; if (hs !== 300) begin
      errors++; $display("FAIL cnt_handshakes got=%0d exp=300", hs); end
    checks++; if (cnt1 !== (CNT_EN ? 8'd255 : 8'd0) || cnt1 !== exp_cnt(mc1)) begin
      errors++; $display("FAIL cnt_saturate got=%0d exp=%0d", cnt1, exp_cnt(mc1)); end
    cnt_clr = 1;
    checks++; if (out1_valid !== 1'b1) begin
      errors++; $display("FAIL cnt_clr_hs got=%b exp=1", out1_valid); end
    cycle();
    cnt_clr = 0;
    #1;
    checks++; if (cnt1 !== 8'd0) begin
      errors++; $display("FAIL cnt_clr got=%0d exp=0", cnt1); end
    cycle();
    #1;
    checks++; if (cnt1 !== exp_cnt(1)) begin
      errors++; $display("FAIL cnt_after_clr got=%0d exp=%0d", cnt1, exp_cnt(1)); end
    in_valid = 0;
    repeat (3) cycle();
    out1_ready = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_valid   = 1'($urandom);
      in_sel     = 1'($urandom);
      in_data    = 16'($urandom);
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 3) == 0);
      cnt_clr    = ($urandom_range(0, 63) == 0);
      #1;
      checks++; if (in_ready !== ((in_sel ? m1.size() : m0.size()) < 2)) begin
        errors++; $display("FAIL rnd_ready[%0d] got=%b occ=%0d/%0d", i, in_ready, m0.size(), m1.size()); end
      checks++; if (out0_valid !== (m0.size() != 0) || (m0.size() != 0 && out0_data !== m0[0])) begin
        errors++; $display("FAIL rnd_out0[%0d] got=%b/%h exp_occ=%0d", i, out0_valid, out0_data, m0.size()); end
      checks++; if (out1_valid !== (m1.size() != 0) || (m1.size() != 0 && out1_data !== m1[0])) begin
        errors++; $display("FAIL rnd_out1[%0d] got=%b/%h exp_occ=%0d", i, out1_valid, out1_data, m1.size()); end
      checks++; if (cnt0 !== exp_cnt(mc0) || cnt1 !== exp_cnt(mc1)) begin
        errors++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, cnt0, cnt1, exp_cnt(mc0), exp_cnt(mc1)); end
      cycle();
    end
    cnt_clr = 0;
  endtask

  task automatic test_reset_midop();
    idle_inputs();
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_sel  = 1'(i);
      in_data = 16'hC000 + 16'(i);
      cycle();
    end
    #1;
    checks++; if (in_ready !== 1'b0 || out0_valid !== 1'b1 || out1_valid !== 1'b1) begin
      errors++; $display("FAIL midop_full got=%b/%b/%b exp=0/1/1", in_ready, out0_valid, out1_valid); end
    #2 rst = 1;
    #1;
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      errors++; $display("FAIL midop_valid got=%b%b exp=00", out1_valid, out0_valid); end
    checks++; if (out0_data !== 16'h0 || out1_data !== 16'h0 || cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      errors++; $display("FAIL midop_clear got=%h/%h/%0d/%0d exp=0", out0_data, out1_data, cnt0, cnt1); end
    m0.delete(); m1.delete(); mc0 = 0; mc1 = 0;
    out0_ready = 1; out1_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0; in_valid = 0; out0_ready = 0; out1_ready = 0;
    #1;
    checks++; if (in_ready !== 1'b1 || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      errors++; $display("FAIL midop_release got=%b/%b/%b exp=1/0/0", in_ready, out0_valid, out1_valid); end
    in_sel = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin
      errors++; $display("FAIL midop_release_sel1 got=%b exp=1", in_ready); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_full_block();
    test_push_pop();
    test_counters();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux216_q.md
DEMUX216_Q -- requirements
Module: demux216_q

Interface
REQ-001 SHALL have parameter: WIDTH, 16, data width of every data path.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  upstream word present.
REQ-005 SHALL have port: in_ready  output  1  block accepts the word this cycle.
REQ-006 SHALL have port: in_data  input  WIDTH  upstream word.
REQ-007 SHALL have port: in_sel  input  1  destination; 0 selects channel 0, 1 selects channel 1.
REQ-008 SHALL have ports: out0_valid / out1_valid  output  1  channel holds a word.
REQ-009 SHALL have ports: out0_ready / out1_ready  input  1  downstream takes the word.
REQ-010 SHALL have ports: out0_data / out1_data  output  WIDTH  head word of the channel.
REQ-011 SHALL have port: cnt_clr  input  1  synchronous clear of both transfer counters.
REQ-012 SHALL have ports: cnt0 / cnt1  output  8  delivered-word count per channel.

Function
REQ-013 SHALL use the input handshake rule: a word is accepted when in_valid=1 and in_ready=1 on a rising edge.
REQ-014 SHALL use the output handshake rule: channel k is popped when outk_valid=1 and outk_ready=1 on a rising edge.
REQ-015 SHALL give each channel a 2-entry FIFO; occupancy count per channel in {0,1,2}.
REQ-016 SHALL drive in_ready = 1 exactly when the FIFO addressed by in_sel holds fewer than 2 entries, combinationally from in_sel and occupancy.
REQ-017 SHALL keep in_ready independent of outk_ready; a full FIFO blocks even when it is popped in the same cycle (no pass-through).
REQ-018 SHALL write an accepted word only into the FIFO selected by in_sel; the other FIFO is unchanged.
REQ-019 SHALL make an accepted word visible on outk_data/outk_valid in the cycle after acceptance when the FIFO was empty (latency 1).
REQ-020 SHALL drive outk_valid = (occupancy_k != 0) and outk_data = oldest entry of FIFO k.
REQ-021 SHALL hold outk_data stable while outk_valid=1 and outk_ready=0.
REQ-022 SHALL leave occupancy unchanged and preserve order on a push and pop of the same non-empty, non-full FIFO in one cycle.
REQ-023 SHALL deliver words per channel in acceptance order; no ordering exists between channels.
REQ-024 SHALL ignore outk_ready while outk_valid=0; a pop of an empty FIFO has no effect.
REQ-025 SHALL wrap the per-channel read/write pointers modulo 2.
REQ-026 SHALL increment cntk by 1 on each channel-k output handshake, saturating at 255.
REQ-027 SHALL give cnt_clr priority: cnt_clr=1 sets cnt0=cnt1=0 on the next edge, even with a concurrent handshake.

Reset
REQ-028 SHALL, while rst=1, immediately force both occupancies and pointers to 0, out0_valid=out1_valid=0 and cnt0=cnt1=0.
REQ-029 SHALL force out0_data/out1_data to 0 during reset.
REQ-030 SHALL drop words held at a reset asserted mid-operation; no handshake completes in a cycle where rst=1.
REQ-031 SHALL drive in_ready=1 on the first edge after rst deasserts (both FIFOs empty).

Configuration
REQ-032 SHALL have the macro DEMUX216_CNT_EN, which includes the transfer counters when defined.
REQ-033 SHALL, without DEMUX216_CNT_EN, keep ports cnt0/cnt1/cnt_clr present, tie cnt0=cnt1=0 and ignore cnt_clr, with no counter flops; data-path behaviour is identical with and without the macro.

Verification
REQ-034 SHALL cover: after reset, in_sel=0, in_data=16'h1234 accepted -> next cycle out0_valid=1, out0_data=16'h1234, out1_valid=0.
REQ-035 SHALL cover: out1_ready=0, three words 16'hA001/A002/A003 to channel 1 -> in_ready=0 for the third with in_sel=1; in_ready=1 if in_sel switches to 0.
REQ-036 SHALL cover: channel 0 holding one word, push 16'h0002 and pop 16'h0001 in the same cycle -> occupancy stays 1, next out0_data=16'h0002.
REQ-037 SHALL cover: 300 handshakes on channel 1 with DEMUX216_CNT_EN -> cnt1=255; cnt_clr pulse with a concurrent handshake -> cnt1=0.
REQ-038 SHALL cover: rst asserted with both FIFOs full -> out0_valid=out1_valid=0 immediately, cnt0=cnt1=0, in_ready=1 after release.
REQ-039 SHALL cover: the build without DEMUX216_CNT_EN -> cnt0=cnt1=0 throughout traffic, and the data outputs match the macro-enabled build cycle for cycle.
